// File: rtl/me_array_pkg.sv
// Shared encodings and width helpers for the parametrised motion-estimation PE array.
package me_array_pkg;

    typedef enum logic [2:0] {
        REF_HOLD = 3'd0,
        REF_DN1  = 3'd1,
        REF_UP1  = 3'd2,
        REF_DNJ  = 3'd3,
        REF_UPJ  = 3'd4
    } ref_mode_t;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int sad_w(input int pixel, input int cols);
        return pixel + $clog2(cols);
    endfunction

endpackage

// File: rtl/me_cur_loader.sv
// Serial current-block loader: assembles CUR_PPC-pixel beats into rows and commits each full row.
// Handshake: a beat is taken on a cycle with cur_valid && cur_ready && !cur_start; cur_ready is high only in LOAD.
module me_cur_loader import me_array_pkg::*; #(
    parameter int PIXEL   = 8,
    parameter int COLS    = 32,
    parameter int ROWS    = 32,
    parameter int CUR_PPC = 2,
    parameter int NUM_CB  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cur_start,
    input  logic [sel_w(NUM_CB)-1:0]     cur_sel,
    input  logic                         cur_valid,
    output logic                         cur_ready,
    input  logic [CUR_PPC*PIXEL-1:0]     cur_data,
    output logic                         cur_done,
    output logic [NUM_CB-1:0]            cb_valid,
    output logic                         row_commit,
    output logic [COLS*PIXEL-1:0]        row_data,
    output logic [sel_w(NUM_CB)-1:0]     tgt_sel,
    output ld_state_t                    state
);
    localparam int BEATS     = COLS / CUR_PPC;
    localparam int BEAT_W    = sel_w(BEATS);
    localparam int ROW_W     = sel_w(ROWS);
    localparam int BEAT_BITS = CUR_PPC * PIXEL;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

    ld_state_t              state_nxt;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [ROW_W-1:0]       row_cnt;
    logic [COLS*PIXEL-1:0]  row_asm;
    logic                   start_ok;
    logic                   beat_acc;

    assign cur_ready  = (state == LD_LOAD);
    assign cur_done   = (state == LD_DONE);
    assign start_ok   = cur_start && (state != LD_DONE);
    assign beat_acc   = cur_valid && cur_ready && !cur_start;
    assign row_commit = beat_acc && (beat_cnt == LAST_BEAT);

    // row_data carries the row including the beat being accepted, so the commit lands in the same cycle.
    always_comb begin
        state_nxt = state;
        row_data  = row_asm;
        if (beat_acc) begin
            row_data[beat_cnt*BEAT_BITS +: BEAT_BITS] = cur_data;
        end
        case (state)
            LD_IDLE: if (cur_start) state_nxt = LD_LOAD;
            LD_LOAD: if (row_commit && (row_cnt == LAST_ROW)) state_nxt = LD_DONE;
            LD_DONE: state_nxt = LD_IDLE;
            default: state_nxt = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LD_IDLE;
            beat_cnt <= '0;
            row_cnt  <= '0;
            row_asm  <= '0;
            tgt_sel  <= '0;
            cb_valid <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                tgt_sel  <= cur_sel;
                beat_cnt <= '0;
                row_cnt  <= '0;
                if (int'(cur_sel) < NUM_CB) cb_valid[cur_sel] <= 1'b0;
            end else if (beat_acc) begin
                row_asm <= row_data;
                if (row_commit) begin
                    beat_cnt <= '0;
                    row_cnt  <= row_cnt + ROW_W'(1);
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
            end
            if ((state == LD_DONE) && (int'(tgt_sel) < NUM_CB)) cb_valid[tgt_sel] <= 1'b1;
        end
    end

endmodule

// File: rtl/me_pe_array_param.sv
// Parametrised SAD PE array: NUM_CB current-block stores, a shifting reference window, registered |ref-cur|.
// Optional per-row SAD outputs are built when ME_ROW_SAD_EN is defined.
module me_pe_array_param import me_array_pkg::*; #(
    parameter int PIXEL   = 8,
    parameter int COLS    = 32,
    parameter int ROWS    = 32,
    parameter int JUMP    = 8,
    parameter int CUR_PPC = 2,
    parameter int NUM_CB  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cur_start,
    input  logic [sel_w(NUM_CB)-1:0]          cur_sel,
    input  logic                              cur_valid,
    output logic                              cur_ready,
    input  logic [CUR_PPC*PIXEL-1:0]          cur_data,
    output logic                              cur_done,
    output logic [NUM_CB-1:0]                 cb_valid,
    input  logic [2:0]                        ref_mode,
    input  logic [COLS*PIXEL-1:0]             ref_top_row,
    input  logic [COLS*PIXEL-1:0]             ref_bot_row,
    input  logic [JUMP*COLS*PIXEL-1:0]        ref_top_blk,
    input  logic [JUMP*COLS*PIXEL-1:0]        ref_bot_blk,
    input  logic [sel_w(NUM_CB)-1:0]          cmp_sel,
    output logic [ROWS*COLS*PIXEL-1:0]        abs_out,
    output logic                              abs_valid,
`ifdef ME_ROW_SAD_EN
    output logic [ROWS*sad_w(PIXEL,COLS)-1:0] row_sad,
    output logic                              row_sad_valid,
`endif
    output ld_state_t                         dbg_state
);
    localparam int RW    = COLS * PIXEL;
    localparam int SEL_W = sel_w(NUM_CB);

    logic [RW-1:0]              ref_win [ROWS];
    logic [RW-1:0]              cur_mem [NUM_CB][ROWS];
    logic                       row_commit;
    logic [RW-1:0]              row_data;
    logic [SEL_W-1:0]           tgt_sel;
    logic                       cmp_hit;
    logic [SEL_W-1:0]           cmp_idx;
    logic [ROWS*COLS*PIXEL-1:0] abs_nxt;

    me_cur_loader #(
        .PIXEL(PIXEL), .COLS(COLS), .ROWS(ROWS), .CUR_PPC(CUR_PPC), .NUM_CB(NUM_CB)
    ) u_loader (
        .clk(clk), .rst(rst), .cur_start(cur_start), .cur_sel(cur_sel),
        .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_data(cur_data),
        .cur_done(cur_done), .cb_valid(cb_valid), .row_commit(row_commit),
        .row_data(row_data), .tgt_sel(tgt_sel), .state(dbg_state)
    );

    // Committed rows enter at the bottom so the first loaded row ends up in row 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_CB; b++)
                for (int r = 0; r < ROWS; r++)
                    cur_mem[b][r] <= '0;
        end else if (row_commit && (int'(tgt_sel) < NUM_CB)) begin
            for (int r = 0; r < ROWS-1; r++) cur_mem[tgt_sel][r] <= cur_mem[tgt_sel][r+1];
            cur_mem[tgt_sel][ROWS-1] <= row_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) ref_win[r] <= '0;
        end else begin
            case (ref_mode)
                REF_DN1: begin
                    ref_win[0] <= ref_top_row;
                    for (int r = 1; r < ROWS; r++) ref_win[r] <= ref_win[r-1];
                end
                REF_UP1: begin
                    for (int r = 0; r < ROWS-1; r++) ref_win[r] <= ref_win[r+1];
                    ref_win[ROWS-1] <= ref_bot_row;
                end
                REF_DNJ: begin
                    for (int r = 0; r < JUMP; r++) ref_win[r] <= ref_top_blk[r*RW +: RW];
                    for (int r = JUMP; r < ROWS; r++) ref_win[r] <= ref_win[r-JUMP];
                end
                REF_UPJ: begin
                    for (int r = 0; r < ROWS-JUMP; r++) ref_win[r] <= ref_win[r+JUMP];
                    for (int k = 0; k < JUMP; k++) ref_win[ROWS-JUMP+k] <= ref_bot_blk[k*RW +: RW];
                end
                default: ;
            endcase
        end
    end

    // The extra sign bit of the widened difference picks which operand order gives the magnitude.
    function automatic logic [PIXEL-1:0] abs_diff(input logic [PIXEL-1:0] a, input logic [PIXEL-1:0] b);
        logic [PIXEL:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[PIXEL] ? (b - a) : d[PIXEL-1:0];
    endfunction

    assign cmp_hit = (int'(cmp_sel) < NUM_CB);
    assign cmp_idx = cmp_hit ? cmp_sel : '0;

    always_comb begin
        abs_nxt = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                abs_nxt[(r*COLS+c)*PIXEL +: PIXEL] =
                    abs_diff(ref_win[r][c*PIXEL +: PIXEL], cur_mem[cmp_idx][r][c*PIXEL +: PIXEL]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abs_out   <= '0;
            abs_valid <= 1'b0;
        end else begin
            abs_out   <= abs_nxt;
            abs_valid <= cmp_hit && cb_valid[cmp_idx];
        end
    end

`ifdef ME_ROW_SAD_EN
    localparam int SAD_W = sad_w(PIXEL, COLS);

    logic [ROWS*SAD_W-1:0] row_sad_nxt;
    logic [SAD_W-1:0]      acc;

    always_comb begin
        row_sad_nxt = '0;
        acc         = '0;
        for (int r = 0; r < ROWS; r++) begin
            acc = '0;
            for (int c = 0; c < COLS; c++) acc = acc + SAD_W'(abs_out[(r*COLS+c)*PIXEL +: PIXEL]);
            row_sad_nxt[r*SAD_W +: SAD_W] = acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_sad       <= '0;
            row_sad_valid <= 1'b0;
        end else begin
            row_sad       <= row_sad_nxt;
            row_sad_valid <= abs_valid;
        end
    end
`endif

endmodule

// File: doc/me_pe_array_param.md
Name: me_pe_array_param

Overview:
- Parametrised successor of the 32x32 four-mode SAD processing-element array used for HEVC integer motion estimation.
- Holds NUM_CB current blocks, loaded serially at CUR_PPC pixels per clock through an internal loader FSM.
- Holds one ROWS x COLS reference window that shifts by 1 or JUMP rows up or down.
- Emits a registered per-pixel absolute difference against a selected current block; sits between the search-window fetch unit and the SAD adder tree.

Parameters:
- PIXEL, 8, bits per pixel.
- COLS, 32, array width in pixels.
- ROWS, 32, array height in pixels.
- JUMP, 8, rows moved per long shift; legal range 2..ROWS-1.
- CUR_PPC, 2, current pixels per input beat; must divide COLS.
- NUM_CB, 8, number of current-block stores; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cur_start  in  1  pulse: begin loading current block cur_sel.
- cur_sel  in  clog2(NUM_CB) (min 1)  target current-block store.
- cur_valid  in  1  beat valid.
- cur_ready  out  1  beat accepted when cur_valid&cur_ready.
- cur_data  in  CUR_PPC*PIXEL  pixel k at bits [k*PIXEL +: PIXEL].
- cur_done  out  1  one-cycle pulse: block fully loaded.
- cb_valid  out  NUM_CB  per-store loaded flag.
- ref_mode  in  3  0 HOLD, 1 DN1, 2 UP1, 3 DNJ, 4 UPJ, 5-7 HOLD.
- ref_top_row  in  COLS*PIXEL  row entering at row 0 on DN1.
- ref_bot_row  in  COLS*PIXEL  row entering at row ROWS-1 on UP1.
- ref_top_blk  in  JUMP*COLS*PIXEL  rows 0..JUMP-1 on DNJ.
- ref_bot_blk  in  JUMP*COLS*PIXEL  rows ROWS-JUMP..ROWS-1 on UPJ.
- Block-port row packing: row k at bits [k*COLS*PIXEL +: COLS*PIXEL].
- cmp_sel  in  clog2(NUM_CB) (min 1)  current block compared.
- abs_out  out  ROWS*COLS*PIXEL  |ref-cur|; pixel (r,c) at bits [(r*COLS+c)*PIXEL +: PIXEL].
- abs_valid  out  1  abs_out qualifies a loaded block.

Behaviour:
- Reset: all storage, abs_out, abs_valid, cb_valid, cur_done and counters go to 0. Loader state is IDLE and cur_ready=0. Reset mid-load discards the partial block.
- Loader FSM states:
  - IDLE: cur_ready=0. cur_start latches cur_sel, clears cb_valid[sel] and the counters, then goes to LOAD.
  - LOAD: cur_ready=1. Each accepted beat writes CUR_PPC pixels into the row assembler at columns beat_cnt*CUR_PPC upward.
  - Row commit: on the beat completing a row (beat_cnt=COLS/CUR_PPC-1), the assembled row is written into row ROWS-1 of the target store, rows r<-r+1 shift up, and row_cnt increments. The commit happens in the same cycle as the beat.
  - After the ROWS-th commit the FSM goes to DONE. The first loaded row ends in row 0.
  - DONE: one cycle. cur_done=1, cb_valid[sel]<=1, cur_ready=0, then IDLE.
- cur_start in LOAD restarts: partial data is abandoned, the new sel is latched, cb_valid[new] is cleared and counters reset; a beat in that same cycle is not accepted. cur_start in DONE is ignored.
- Reference shift (every edge, independent of the loader):
  - DN1: row r<=row r-1, row 0<=ref_top_row.
  - UP1: row r<=row r+1, row ROWS-1<=ref_bot_row.
  - DNJ: row r<=row r-JUMP for r>=JUMP, rows 0..JUMP-1 <= ref_top_blk.
  - UPJ: row r<=row r+JUMP for r<ROWS-JUMP, upper JUMP rows <= ref_bot_blk.
  - HOLD (including codes 5-7): reference window unchanged.
- abs_out: registered from the current reference and store contents. A shift at edge k is reflected at edge k+1. Unsigned subtraction with PIXEL+1-bit intermediate, result PIXEL bits, never saturates.
- abs_valid <= cb_valid[cmp_sel] at the same latency. It is 0 while the compared store is being loaded.
- cmp_sel >= NUM_CB: abs_valid=0, abs_out compares store 0.

Optional Feature:
- Macro ME_ROW_SAD_EN.
- When defined, adds output row_sad, width ROWS*(PIXEL+clog2(COLS)). Row r at bits [r*W +: W] holds the sum of abs_out row r, registered one cycle after abs_out, plus row_sad_valid delayed from abs_valid. Both reset to 0.
- When undefined, neither port exists and no adders are built.

Decomposition:
- Package me_array_pkg:
  - ref_mode encodings REF_HOLD, REF_DN1, REF_UP1, REF_DNJ, REF_UPJ.
  - Loader state encodings.
  - clog2-based width helper functions.
- Sub-module me_cur_loader: FSM, beat/row counters and row assembler. It outputs row_commit, row_data and tgt_sel to the array top.

Test Plan:
- Reset then load: cur_start with cur_sel=3, then 512 beats of the pixel index (mod 256), no stalls. Expect cur_done at cycle 513 after the first beat, cb_valid=8'h08, store 3 row 0 col 0 = 0, row 31 col 31 = 255 (1023 mod 256).
- Stalls: toggle cur_valid 50% during the load. Expect identical contents and cur_done only after 512 accepted beats.
- Restart: cur_start(sel=1) mid-load after 100 beats. Expect cb_valid[1]=0 until 512 further beats, and no stale data.
- Reference shifts: window filled with ref(r,c)=r, store 3 all zeros, cmp_sel=3.
  - DN1 with ref_top_row=8'hAA: next cycle abs_out row 0=8'hAA, row 1=0, row 31=30.
  - UPJ with a bottom block of 8'h55: rows 24..31=8'h55, row 0=8.
- Subtraction: ref=8'h10, cur=8'hF0. Expect abs=8'hE0; swapping the operands gives the same result.
- ME_ROW_SAD_EN: all abs values 8'hFF. Expect row_sad per row = 8160 (13 bits), two cycles after the shift edge.
